// File: rtl/prom_arb_pkg.sv
// Shared helpers for the pROM read arbiter: requester-id sizing and one-hot decode.
package prom_arb_pkg;

    localparam int MAX_REQ = 8;

    // Requester id width; never narrower than one bit so a 2-requester tag still has an id field.
    function automatic int calc_id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input logic [2:0] id);
        logic [MAX_REQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last winner and wraps modulo N.
module rr_arbiter
    import prom_arb_pkg::*;
#(
    parameter int N = 2,
    localparam int ID_W = calc_id_w(N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] grant_id
);

    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;
    logic            found;
    int              idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int k = 1; k <= N; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (advance) begin
            rr_ptr_d = grant_id;
        end
    end

    // Reset to the last requester so requester 0 wins the first contest.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr_q <= ID_W'(N - 1);
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/prom_read_arbiter.sv
// Shares one registered-read pROM among NUM_REQ requesters; a tag pipeline steers each
// returned word back to the requester that issued it.
module prom_read_arbiter
    import prom_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_data,
    output logic [ADDR_W-1:0]         rom_ad,
    output logic                      rom_ce,
    output logic                      rom_oce,
    output logic                      rom_reset,
    input  logic [DATA_W-1:0]         rom_dout
);

    localparam int ID_W = calc_id_w(NUM_REQ);

    // Handshake: a request is taken on the rising edge where req_valid[i] & req_ready[i];
    // the requester holds valid and address stable until then. Responses cannot be stalled.
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               accept;
    logic [ADDR_W-1:0]  win_addr;

    logic [READ_LAT-1:0] tag_v_q;
    logic [READ_LAT-1:0] tag_v_d;
    logic [ID_W-1:0]     tag_id_q [READ_LAT];
    logic [ID_W-1:0]     tag_id_d [READ_LAT];
    logic [ADDR_W-1:0]   last_ad_q;
    logic [ADDR_W-1:0]   last_ad_d;

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req_valid),
        .advance (accept),
        .grant   (grant),
        .grant_id(grant_id)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign win_addr  = req_addr[int'(grant_id)*ADDR_W +: ADDR_W];
    assign rom_reset = reset;

    always_comb begin
        tag_v_d     = '0;
        tag_v_d[0]  = accept;
        tag_id_d[0] = grant_id;
        for (int k = 1; k < READ_LAT; k++) begin
            tag_v_d[k]  = tag_v_q[k-1];
            tag_id_d[k] = tag_id_q[k-1];
        end
    end

    // Idle cycles replay the last granted address so the pROM address pins stay quiet.
    always_comb begin
        last_ad_d = last_ad_q;
        rom_ad    = last_ad_q;
        if (accept) begin
            last_ad_d = win_addr;
            rom_ad    = win_addr;
        end
    end

    always_comb begin
        rom_ce  = accept | (|tag_v_q);
        rom_oce = (READ_LAT == 1) ? 1'b1 : rom_ce;
    end

    always_comb begin
        rsp_valid = '0;
        rsp_data  = '0;
        if (tag_v_q[READ_LAT-1]) begin
            rsp_valid = NUM_REQ'(onehot(3'(tag_id_q[READ_LAT-1])));
            rsp_data  = rom_dout;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_v_q   <= '0;
            last_ad_q <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            tag_v_q   <= tag_v_d;
            last_ad_q <= last_ad_d;
            for (int k = 0; k < READ_LAT; k++) begin
                tag_id_q[k] <= tag_id_d[k];
            end
        end
    end

endmodule

// File: tb/tb_prom_read_arbiter.sv
// Directed bench for prom_read_arbiter: three configurations, each behind a pROM model
// whose byte i holds 8'h10+i.
module tb_prom_read_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // a: NUM_REQ=2 READ_LAT=1
    logic [1:0] a_req_valid = '0;
    logic [7:0] a_req_addr = '0;
    logic [1:0] a_req_ready, a_rsp_valid;
    logic [7:0] a_rsp_data;
    logic [3:0] a_rom_ad;
    logic       a_rom_ce, a_rom_oce, a_rom_reset;
    logic [7:0] a_rom_dout = '0;
    logic [31:0] a_q[$];

    // b: NUM_REQ=2 READ_LAT=2
    logic [1:0] b_req_valid = '0;
    logic [7:0] b_req_addr = '0;
    logic [1:0] b_req_ready, b_rsp_valid;
    logic [7:0] b_rsp_data;
    logic [3:0] b_rom_ad;
    logic       b_rom_ce, b_rom_oce, b_rom_reset;
    logic [7:0] b_mem_q = '0;
    logic [7:0] b_rom_dout = '0;
    logic [31:0] b_q[$];

    // c: NUM_REQ=3 READ_LAT=1
    logic [2:0]  c_req_valid = '0;
    logic [11:0] c_req_addr = '0;
    logic [2:0]  c_req_ready, c_rsp_valid;
    logic [7:0]  c_rsp_data;
    logic [3:0]  c_rom_ad;
    logic        c_rom_ce, c_rom_oce, c_rom_reset;
    logic [7:0]  c_rom_dout = '0;
    logic [31:0] c_q[$];

    prom_read_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(8), .READ_LAT(1)) dut_a (
        .clk(clk), .reset(rst), .req_valid(a_req_valid), .req_addr(a_req_addr),
        .req_ready(a_req_ready), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data),
        .rom_ad(a_rom_ad), .rom_ce(a_rom_ce), .rom_oce(a_rom_oce),
        .rom_reset(a_rom_reset), .rom_dout(a_rom_dout)
    );

    prom_read_arbiter #(.NUM_REQ(2), .ADDR_W(4), .DATA_W(8), .READ_LAT(2)) dut_b (
        .clk(clk), .reset(rst), .req_valid(b_req_valid), .req_addr(b_req_addr),
        .req_ready(b_req_ready), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data),
        .rom_ad(b_rom_ad), .rom_ce(b_rom_ce), .rom_oce(b_rom_oce),
        .rom_reset(b_rom_reset), .rom_dout(b_rom_dout)
    );

    prom_read_arbiter #(.NUM_REQ(3), .ADDR_W(4), .DATA_W(8), .READ_LAT(1)) dut_c (
        .clk(clk), .reset(rst), .req_valid(c_req_valid), .req_addr(c_req_addr),
        .req_ready(c_req_ready), .rsp_valid(c_rsp_valid), .rsp_data(c_rsp_data),
        .rom_ad(c_rom_ad), .rom_ce(c_rom_ce), .rom_oce(c_rom_oce),
        .rom_reset(c_rom_reset), .rom_dout(c_rom_dout)
    );

    // pROM models: registered read, plus an output register gated by oce for b.
    always @(posedge clk) begin
        if (a_rom_reset) a_rom_dout <= '0;
        else if (a_rom_ce) a_rom_dout <= {4'h1, a_rom_ad};
        if (c_rom_reset) c_rom_dout <= '0;
        else if (c_rom_ce) c_rom_dout <= {4'h1, c_rom_ad};
        if (b_rom_reset) begin
            b_mem_q    <= '0;
            b_rom_dout <= '0;
        end else begin
            if (b_rom_ce) b_mem_q <= {4'h1, b_rom_ad};
            if (b_rom_oce) b_rom_dout <= b_mem_q;
        end
    end

    // Scoreboards: each entry is {cycle, one-hot rsp_valid, data}.
    always @(negedge clk) begin
        if (a_rsp_valid != '0) begin
            if (a_q.size() == 0) check("a_spurious_rsp", 32'(a_rsp_valid), 32'd0);
            else check("a_rsp", {16'(cyc), 8'(a_rsp_valid), a_rsp_data}, a_q.pop_front());
        end
        if (b_rsp_valid != '0) begin
            if (b_q.size() == 0) check("b_spurious_rsp", 32'(b_rsp_valid), 32'd0);
            else check("b_rsp", {16'(cyc), 8'(b_rsp_valid), b_rsp_data}, b_q.pop_front());
        end
        if (c_rsp_valid != '0) begin
            if (c_q.size() == 0) check("c_spurious_rsp", 32'(c_rsp_valid), 32'd0);
            else check("c_rsp", {16'(cyc), 8'(c_rsp_valid), c_rsp_data}, c_q.pop_front());
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        a_req_valid = '0;
        b_req_valid = '0;
        c_req_valid = '0;
        #1;
        check("rst_a_rsp", {a_rsp_valid, a_rsp_data}, '0);
        check("rst_b_rsp", {b_rsp_valid, b_rsp_data}, '0);
        check("rst_c_rsp", {c_rsp_valid, c_rsp_data}, '0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic step_a(input logic [1:0] v, input logic [3:0] ad0, input logic [3:0] ad1,
                          input logic [1:0] exp_rdy, input string tag);
        logic [7:0] d;
        @(posedge clk);
        #2;
        a_req_valid = v;
        a_req_addr  = {ad1, ad0};
        #1;
        check(tag, 32'(a_req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            d = 8'h10 + 8'(exp_rdy[0] ? ad0 : ad1);
            a_q.push_back({16'(cyc + 1), 8'(exp_rdy), d});
        end
    endtask

    task automatic step_b(input logic [1:0] v, input logic [3:0] ad0, input logic [3:0] ad1,
                          input logic [1:0] exp_rdy, input logic exp_oce, input bit track,
                          input string tag);
        logic [7:0] d;
        @(posedge clk);
        #2;
        b_req_valid = v;
        b_req_addr  = {ad1, ad0};
        #1;
        check(tag, 32'(b_req_ready), 32'(exp_rdy));
        check({tag, "_oce"}, 32'(b_rom_oce), 32'(exp_oce));
        if (track && exp_rdy != '0) begin
            d = 8'h10 + 8'(exp_rdy[0] ? ad0 : ad1);
            b_q.push_back({16'(cyc + 2), 8'(exp_rdy), d});
        end
    endtask

    task automatic step_c(input logic [2:0] v, input logic [3:0] ad1, input logic [3:0] ad2,
                          input logic [2:0] exp_rdy, input string tag);
        logic [7:0] d;
        @(posedge clk);
        #2;
        c_req_valid = v;
        c_req_addr  = {ad2, ad1, 4'h0};
        #1;
        check(tag, 32'(c_req_ready), 32'(exp_rdy));
        if (exp_rdy != '0) begin
            d = 8'h10 + 8'(exp_rdy[1] ? ad1 : ad2);
            c_q.push_back({16'(cyc + 1), 8'(exp_rdy), d});
        end
    endtask

    initial begin
        // single read from requester 0
        do_reset();
        step_a(2'b01, 4'd4, 4'd0, 2'b01, "t1_grant0");
        step_a(2'b00, 4'd0, 4'd0, 2'b00, "t1_idle");
        step_a(2'b00, 4'd0, 4'd0, 2'b00, "t1_idle");

        // both requesters hold valid: strict alternation
        do_reset();
        for (int k = 0; k < 6; k++) begin
            step_a(2'b11, 4'd1, 4'd2, (k % 2 == 0) ? 2'b01 : 2'b10, "t2_rotate");
        end
        step_a(2'b00, 4'd0, 4'd0, 2'b00, "t2_idle");

        // requester 1 streams the whole ROM back-to-back
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step_a(2'b10, 4'd0, 4'(i), 2'b10, "t3_stream");
        end
        step_a(2'b00, 4'd0, 4'd0, 2'b00, "t3_idle");
        step_a(2'b00, 4'd0, 4'd0, 2'b00, "t3_idle");

        // reset with reads in flight discards them; requester 0 wins afterwards
        do_reset();
        step_b(2'b01, 4'd3, 4'd0, 2'b01, 1'b1, 1'b0, "t4_g0");
        step_b(2'b10, 4'd0, 4'd5, 2'b10, 1'b1, 1'b0, "t4_g1");
        @(posedge clk);
        #2;
        rst = 1'b1;
        b_req_valid = '0;
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_flush", {b_rsp_valid, b_rsp_data}, '0);
        end
        step_b(2'b11, 4'd8, 4'd9, 2'b01, 1'b1, 1'b1, "t4_first");
        step_b(2'b11, 4'd8, 4'd9, 2'b10, 1'b1, 1'b1, "t4_second");
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, "t4_drain");
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, "t4_drain");
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, "t4_idle");

        // three requesters, only 1 and 2 active
        do_reset();
        for (int k = 0; k < 4; k++) begin
            step_c(3'b110, 4'd9, 4'd10, (k % 2 == 0) ? 3'b010 : 3'b100, "t5_rotate");
        end
        step_c(3'b000, 4'd0, 4'd0, 3'b000, "t5_idle");

        // READ_LAT=2 single read and oce activity
        do_reset();
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, "t6_idle");
        step_b(2'b01, 4'd7, 4'd0, 2'b01, 1'b1, 1'b1, "t6_grant");
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, "t6_wait1");
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b1, 1'b1, "t6_wait2");
        step_b(2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, "t6_idle_after");

        repeat (4) @(posedge clk);
        check("a_missing_rsp", 32'(a_q.size()), 32'd0);
        check("b_missing_rsp", 32'(b_q.size()), 32'd0);
        check("c_missing_rsp", 32'(c_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prom_read_arbiter.md
Name: prom_read_arbiter

Overview:
Shares one single-port Gowin pROM instance (registered synchronous read) between NUM_REQ independent read requesters. Each requester uses a valid/ready request handshake. The block picks one request per cycle by round-robin, drives the pROM address and enables, and tracks each read through a latency pipeline. It then routes the returned data to the originating requester with a one-hot response strobe. It sits between the pROM primitive and the LED/display logic or any other ROM consumers.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
ADDR_W, 4, pROM address width
DATA_W, 8, pROM data width
READ_LAT, 1, cycles from accepting edge to valid dout (1 = bypass, 2 = output-register mode; legal 1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester read request
req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W]
req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i]
rsp_valid  out  NUM_REQ  one-hot; data for requester i is on rsp_data this cycle
rsp_data  out  DATA_W  shared read-data bus
rom_ad  out  ADDR_W  to pROM ad
rom_ce  out  1  to pROM ce
rom_oce  out  1  to pROM oce
rom_reset  out  1  to pROM reset
rom_dout  in  DATA_W  from pROM dout

Behaviour:
- Reset (async assert, sync release): tag pipeline cleared, rr_ptr = NUM_REQ-1 so requester 0 has first priority, rsp_valid = 0, rsp_data = 0.
- rom_reset = reset, combinational.
- Arbitration (combinational, same cycle):
  - Winner is the first i with req_valid[i], scanning from rr_ptr+1 upward with wrap modulo NUM_REQ.
  - req_ready[winner] = 1; all others 0. No valid requests gives req_ready = 0.
  - req_ready may depend on req_valid.
  - Requesters must hold req_valid and req_addr stable until accepted.
- On an accept edge, rr_ptr <= winner. With no accept, rr_ptr holds.
- ROM drive:
  - rom_ad = req_addr of the winner; when idle, rom_ad holds the last granted address (registered copy) to avoid toggling.
  - rom_ce = accept | any tag stage valid.
  - rom_oce = 1 when READ_LAT = 1; otherwise rom_oce = rom_ce.
- Tag pipeline: READ_LAT stages, each {valid, id[ID_W-1:0]} with ID_W = max(1, clog2(NUM_REQ)).
  - Stage 0 <= {accept, winner} at every edge.
  - Stage k <= stage k-1.
- Response:
  - rsp_valid = onehot(stage[READ_LAT-1].id) gated by stage[READ_LAT-1].valid.
  - rsp_data = rom_dout when rsp_valid is nonzero, else 0.
  - rsp_valid asserts exactly READ_LAT cycles after the accepting edge.
- Throughput and ordering: one read per cycle sustained, no bubbles. Responses are in acceptance order.
- No response backpressure: a requester must consume rsp_data in the cycle rsp_valid asserts.
- Reset mid-operation: in-flight reads are discarded and no rsp_valid follows. Requesters reissue.
- A single requester with continuous req_valid is granted every cycle when the others are idle.
- With all requesters active, grants rotate strictly 0,1,...,NUM_REQ-1,0.

Decomposition:
- Package prom_arb_pkg: function onehot(id), and a localparam helper computing ID_W from NUM_REQ.
- One sub-module, rr_arbiter:
  - Parameter N.
  - Ports clk, reset, req[N], advance, grant[N] (one-hot), grant_id.
  - Owns rr_ptr.
- Tag pipeline and ROM muxing stay in prom_read_arbiter.

Test Plan:
1. ROM image byte i = 8'h10+i. Requester 0 pulses addr 4 alone -> req_ready[0] same cycle; rsp_valid = 2'b01 and rsp_data = 8'h14 one cycle after accept (READ_LAT=1).
2. Both requesters hold valid (r0 addr 1, r1 addr 2) for 6 cycles -> grants 0,1,0,1,0,1; responses 11,12,11,12,11,12 with matching one-hot rsp_valid.
3. Requester 1 alone issues addrs 0..15 back-to-back -> 16 accepts in 16 cycles, responses 8'h10..8'h1F in order with no gaps.
4. Two reads in flight with READ_LAT=2, assert reset for 1 cycle -> no rsp_valid afterwards. With both then requesting, requester 0 is granted first.
5. NUM_REQ=3, only requesters 1 and 2 active -> alternating grants 1,2,1,2; rsp_valid[0] never asserts.
6. READ_LAT=2, single read addr 7 -> rsp_valid 2 cycles after accept, rsp_data 8'h17; rom_oce high during those cycles and low when idle.
